// File: rtl/instr_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module     : instr_sequencer_pkg
// Description: Opcodes, A-source selects, FSM states and decode record
//              shared by the instruction sequencer.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_LDI  = 4'hD;
    localparam logic [3:0] OP_RST  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ACC_HOLD = 3'd0;
    localparam logic [2:0] ACC_IMM  = 3'd1;
    localparam logic [2:0] ACC_INC  = 3'd2;
    localparam logic [2:0] ACC_ADD  = 3'd3;
    localparam logic [2:0] ACC_REG  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] acc_sel;
        logic       acc_we_en;
        logic       reg_we_en;
        logic       is_rst;
        logic       is_halt;
        logic       illegal;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
//------------------------------------------------------------------------------
// Module     : instr_sequencer_if
// Description: ROM fetch and A/R datapath control bundle of the sequencer.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 12,
    parameter int ADDR_WIDTH  = 4,
    parameter int IMM_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [INSTR_WIDTH-1:0] rom_data;
    logic                   dp_ready;
    logic [2:0]             acc_sel;
    logic                   acc_we;
    logic                   reg_we;
    logic [IMM_WIDTH-1:0]   imm;
    logic                   halted;
    logic                   illegal;

    modport master (
        output rom_addr, acc_sel, acc_we, reg_we, imm, halted, illegal,
        input  rom_data, dp_ready
    );

    modport slave (
        input  rom_addr, acc_sel, acc_we, reg_we, imm, halted, illegal,
        output rom_data, dp_ready
    );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer_decode.sv
//------------------------------------------------------------------------------
// Module     : instr_decode
// Description: Combinational opcode decoder for the instruction sequencer.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode
    import instr_sequencer_pkg::*;
(
    input  wire logic [3:0] i_opcode,
    output dec_t            o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_ADD:  begin o_dec.acc_sel = ACC_ADD; o_dec.acc_we_en = 1'b1; end
            OP_INC:  begin o_dec.acc_sel = ACC_INC; o_dec.acc_we_en = 1'b1; end
            OP_LD:   begin o_dec.acc_sel = ACC_REG; o_dec.acc_we_en = 1'b1; end
            OP_ST:   o_dec.reg_we_en = 1'b1;
            OP_NOP:  ;
            OP_LDI:  begin o_dec.acc_sel = ACC_IMM; o_dec.acc_we_en = 1'b1; end
            OP_RST:  o_dec.is_rst  = 1'b1;
            OP_HALT: o_dec.is_halt = 1'b1;
            // Undefined opcodes behave as NOP but are flagged.
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module     : instr_sequencer
// Description: Fetch/decode/execute controller for the 16x12 program ROM and
//              the A/R datapath, with free-run, single-step and halt.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = 12,
    parameter int ADDR_WIDTH  = 4,
    parameter int OPC_WIDTH   = 4,
    parameter int IMM_WIDTH   = 4
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          run,
    input  wire logic          step,
    instr_sequencer_if.master  bus
);

    localparam logic [INSTR_WIDTH-1:0] c_IR_RESET =
        {OP_NOP, {(INSTR_WIDTH-OPC_WIDTH){1'b0}}};

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   step_mode_q, step_mode_d;
    logic [2:0]             acc_sel_q, acc_sel_d;
    logic [IMM_WIDTH-1:0]   imm_q, imm_d;
    logic                   halted_q, halted_d;
    logic                   illegal_q, illegal_d;

    dec_t dec;
    logic w_commit;
    logic w_unused_ir;

    instr_decode u_decode (
        .i_opcode (ir_q[INSTR_WIDTH-1 -: OPC_WIDTH]),
        .o_dec    (dec)
    );

    assign w_unused_ir = ^ir_q[INSTR_WIDTH-OPC_WIDTH-IMM_WIDTH-1:0];
    assign w_commit    = (state_q == ST_EXEC) && bus.dp_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        step_mode_d = step_mode_q;
        acc_sel_d   = acc_sel_q;
        imm_d       = imm_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // RUN wins when both are requested together.
                if (run || step) begin
                    state_d     = ST_FETCH;
                    step_mode_d = !run;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.rom_data;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                acc_sel_d = dec.acc_sel;
                imm_d     = ir_q[INSTR_WIDTH-OPC_WIDTH-1 -: IMM_WIDTH];
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.dp_ready) begin
                    acc_sel_d = ACC_HOLD;
                    imm_d     = '0;
                    illegal_d = dec.illegal;
                    if (dec.is_rst)
                        pc_d = '0;
                    if (dec.is_halt) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (run && !step_mode_q) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= c_IR_RESET;
            step_mode_q <= 1'b0;
            acc_sel_q   <= ACC_HOLD;
            imm_q       <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            step_mode_q <= step_mode_d;
            acc_sel_q   <= acc_sel_d;
            imm_q       <= imm_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    // Strobes are combinational so each lasts exactly the committing cycle.
    assign bus.rom_addr = pc_q;
    assign bus.acc_sel  = acc_sel_q;
    assign bus.imm      = imm_q;
    assign bus.acc_we   = w_commit && dec.acc_we_en;
    assign bus.reg_we   = w_commit && dec.reg_we_en;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// Module     : tb_instr_sequencer
// Description: Self-checking bench for instr_sequencer.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic run;
    logic step;

    instr_sequencer_if #(.INSTR_WIDTH(12), .ADDR_WIDTH(4), .IMM_WIDTH(4)) ifc ();

    logic [11:0] rom [16];
    assign ifc.rom_data = rom[ifc.rom_addr];

    instr_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .step  (step),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] t_addr [64];
    logic [2:0] t_sel  [64];
    logic [3:0] t_imm  [64];
    bit         t_awe  [64];
    bit         t_rwe  [64];

    typedef struct {
        logic [11:0] instr;
        logic [2:0]  sel;
        bit          awe;
        bit          rwe;
        bit          ill;
        logic [3:0]  next_addr;
        bit          halt;
    } vec_t;

    typedef struct {
        bit         is_reg;
        logic [2:0] sel;
        logic [3:0] imm;
    } ev_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        ifc.dp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 12'hC00;
    endtask

    task automatic trace(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            t_addr[k] = ifc.rom_addr;
            t_sel[k]  = ifc.acc_sel;
            t_imm[k]  = ifc.imm;
            t_awe[k]  = ifc.acc_we;
            t_rwe[k]  = ifc.reg_we;
        end
    endtask

    // Instruction-level reference: walk the program and list datapath commits.
    task automatic model_run(output ev_t evs[$], output int a_fin, output int r_fin,
                             output int n_ill);
        int a = 0, r = 0;
        logic [11:0] w;
        logic [3:0] op, im;
        evs = {};
        n_ill = 0;
        for (int pc = 0; pc < 15; pc++) begin
            w = rom[pc];
            op = w[11:8];
            im = w[7:4];
            case (op)
                4'h5: begin a = (a + r) % 256; evs.push_back('{0, 3'd3, im}); end
                4'h9: begin a = (a + 1) % 256; evs.push_back('{0, 3'd2, im}); end
                4'hA: begin a = r;             evs.push_back('{0, 3'd4, im}); end
                4'hB: begin r = a;             evs.push_back('{1, 3'd0, im}); end
                4'hC: ;
                4'hD: begin a = int'(im);      evs.push_back('{0, 3'd1, im}); end
                default: n_ill++;
            endcase
        end
        a_fin = a;
        r_fin = r;
    endtask

    vec_t vecs [9];
    logic [3:0] ops [14];

    initial begin
        int n_awe, n_rwe, n_ill, sel_s, imm_s;
        vec_t v;
        logic [3:0] exp_imm;

        vecs[0] = '{12'h5A0, 3'd3, 1, 0, 0, 4'd1, 0};
        vecs[1] = '{12'h900, 3'd2, 1, 0, 0, 4'd1, 0};
        vecs[2] = '{12'hA30, 3'd4, 1, 0, 0, 4'd1, 0};
        vecs[3] = '{12'hB00, 3'd0, 0, 1, 0, 4'd1, 0};
        vecs[4] = '{12'hC00, 3'd0, 0, 0, 0, 4'd1, 0};
        vecs[5] = '{12'hD7F, 3'd1, 1, 0, 0, 4'd1, 0};
        vecs[6] = '{12'hE00, 3'd0, 0, 0, 0, 4'd0, 0};
        vecs[7] = '{12'hF00, 3'd0, 0, 0, 0, 4'd1, 1};
        vecs[8] = '{12'h300, 3'd0, 0, 0, 1, 4'd1, 0};
        ops = '{4'h5, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h1,
                4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8};

        // Reset state
        fill_nop();
        do_reset();
        chk("reset_rom_addr", ifc.rom_addr, 0);
        chk("reset_acc_sel", ifc.acc_sel, 0);
        chk("reset_acc_we", ifc.acc_we, 0);
        chk("reset_reg_we", ifc.reg_we, 0);
        chk("reset_imm", ifc.imm, 0);
        chk("reset_halted", ifc.halted, 0);
        chk("reset_illegal", ifc.illegal, 0);

        // D20 / 900 / B00 free-run at full speed
        rom[0] = 12'hD20; rom[1] = 12'h900; rom[2] = 12'hB00; rom[3] = 12'hF00;
        ifc.dp_ready = 1'b1;
        run = 1'b1;
        trace(9);
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("prog_awe_c%0d", k), t_awe[k], int'(k == 3 || k == 6));
            chk($sformatf("prog_rwe_c%0d", k), t_rwe[k], int'(k == 9));
            if (k % 3 == 1) chk($sformatf("prog_addr_c%0d", k), t_addr[k], (k - 1) / 3);
        end
        chk("prog_ldi_sel", t_sel[3], 1);
        chk("prog_ldi_imm", t_imm[3], 2);
        chk("prog_inc_sel", t_sel[6], 2);

        // Stall in EXEC for 4 cycles
        do_reset();
        fill_nop();
        rom[0] = 12'h500;
        run = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 7) ifc.dp_ready = 1'b1;
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                chk($sformatf("stall_sel_c%0d", k), ifc.acc_sel, 3);
                chk($sformatf("stall_awe_c%0d", k), ifc.acc_we, 0);
            end
            if (k == 7) begin
                chk("stall_commit_awe", ifc.acc_we, 1);
                chk("stall_commit_sel", ifc.acc_sel, 3);
            end
            if (k == 8) begin
                chk("stall_after_awe", ifc.acc_we, 0);
                chk("stall_next_fetch_addr", ifc.rom_addr, 1);
            end
            if (k == 9) chk("stall_fetch_done_addr", ifc.rom_addr, 2);
        end

        // Single-step table: one instruction per STEP, extra STEP mid-flight ignored
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            exp_imm = v.instr[7:4];
            do_reset();
            fill_nop();
            rom[0] = v.instr;
            ifc.dp_ready = 1'b1;
            step = 1'b1;
            n_awe = 0; n_rwe = 0; n_ill = 0; sel_s = -1; imm_s = -1;
            for (int k = 1; k <= 14; k++) begin
                @(posedge clk); #1;
                step = (k == 2);
                @(negedge clk);
                if (ifc.acc_we) begin
                    n_awe++;
                    sel_s = int'(ifc.acc_sel);
                    imm_s = int'(ifc.imm);
                end
                if (ifc.reg_we) n_rwe++;
                if (ifc.illegal) n_ill++;
            end
            chk($sformatf("step_%03h_acc_we", v.instr), n_awe, int'(v.awe));
            chk($sformatf("step_%03h_reg_we", v.instr), n_rwe, int'(v.rwe));
            chk($sformatf("step_%03h_illegal", v.instr), n_ill, int'(v.ill));
            chk($sformatf("step_%03h_addr", v.instr), ifc.rom_addr, int'(v.next_addr));
            chk($sformatf("step_%03h_halted", v.instr), ifc.halted, int'(v.halt));
            if (v.awe) begin
                chk($sformatf("step_%03h_sel", v.instr), sel_s, int'(v.sel));
                chk($sformatf("step_%03h_imm", v.instr), imm_s, int'(exp_imm));
            end
        end

        // RST at 14, RST at 15, plain wrap: fetch k happens on sample 3k+1
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            fill_nop();
            if (sc == 0) rom[14] = 12'hE00;
            if (sc == 1) rom[15] = 12'hE00;
            ifc.dp_ready = 1'b1;
            run = 1'b1;
            trace(49);
            for (int k = 14; k <= 16; k++) begin
                int exp_a;
                if (sc == 0) exp_a = (k <= 14) ? k : k - 15;
                else         exp_a = k % 16;
                chk($sformatf("wrap%0d_fetch%0d", sc, k), t_addr[3 * k + 1], exp_a);
            end
        end

        // HALT: sticky against RUN, cleared by asynchronous reset
        do_reset();
        fill_nop();
        rom[0] = 12'hF00;
        ifc.dp_ready = 1'b1;
        run = 1'b1;
        trace(4);
        chk("halt_set", ifc.halted, 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            run = ~run;
            @(negedge clk);
        end
        chk("halt_sticky", ifc.halted, 1);
        chk("halt_addr", ifc.rom_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("halt_async_clear", ifc.halted, 0);
        chk("halt_async_pc", ifc.rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset during a stalled EXEC
        do_reset();
        fill_nop();
        rom[0] = 12'h500;
        run = 1'b1;
        trace(4);
        chk("areset_pre_sel", ifc.acc_sel, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_sel", ifc.acc_sel, 0);
        chk("areset_addr", ifc.rom_addr, 0);
        chk("areset_awe", ifc.acc_we, 0);
        ifc.dp_ready = 1'b1;
        n_awe = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ifc.acc_we) n_awe++;
        end
        chk("areset_no_commit", n_awe, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized programs against the instruction-level model
        for (int p = 0; p < 6; p++) begin
            ev_t evs[$];
            ev_t e;
            int a_exp, r_exp, ill_exp, a_dp, r_dp, ill_seen;
            bit done;
            do_reset();
            for (int i = 0; i < 15; i++)
                rom[i] = {ops[$urandom_range(0, 13)], 4'($urandom), 4'($urandom)};
            rom[15] = 12'hF00;
            model_run(evs, a_exp, r_exp, ill_exp);
            a_dp = 0; r_dp = 0; ill_seen = 0; done = 0;
            run = 1'b1;
            step = p[0];
            for (int c = 0; c < 3000 && !done; c++) begin
                @(posedge clk); #1;
                ifc.dp_ready = 1'($urandom_range(0, 1));
                step = 1'b0;
                @(negedge clk);
                if (ifc.acc_we && ifc.reg_we) chk("rnd_dual_strobe", 1, 0);
                if (ifc.acc_we || ifc.reg_we) begin
                    if (evs.size() == 0) begin
                        chk("rnd_extra_commit", 1, 0);
                    end else begin
                        e = evs.pop_front();
                        chk("rnd_commit_kind", int'(ifc.reg_we), int'(e.is_reg));
                        if (ifc.acc_we) begin
                            chk("rnd_commit_sel", ifc.acc_sel, e.sel);
                            if (e.sel == 3'd1) chk("rnd_commit_imm", ifc.imm, e.imm);
                        end
                    end
                    if (ifc.reg_we) r_dp = a_dp;
                    else case (ifc.acc_sel)
                        3'd1: a_dp = int'(ifc.imm);
                        3'd2: a_dp = (a_dp + 1) % 256;
                        3'd3: a_dp = (a_dp + r_dp) % 256;
                        3'd4: a_dp = r_dp;
                        default: ;
                    endcase
                end
                if (ifc.illegal) ill_seen++;
                if (ifc.halted) done = 1;
            end
            chk($sformatf("rnd%0d_halted", p), int'(done), 1);
            chk($sformatf("rnd%0d_left", p), evs.size(), 0);
            chk($sformatf("rnd%0d_acc", p), a_dp, a_exp);
            chk($sformatf("rnd%0d_reg", p), r_dp, r_exp);
            chk($sformatf("rnd%0d_illegal", p), ill_seen, ill_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute controller for the 16x12 program ROM and the accumulator (A) / scratch register (R) datapath.
- Drives the ROM address from an internal program counter (PC) and latches the 12-bit instruction word.
- Decodes the opcode and issues single-cycle write strobes plus source selects to the datapath, gated by a datapath-ready handshake.
- Supports free-run, single-step and halt.

Parameters:
- INSTR_WIDTH, 12, ROM word width.
- ADDR_WIDTH, 4, ROM address / PC width (16 words).
- OPC_WIDTH, 4, opcode field = INSTR[11:8].
- IMM_WIDTH, 4, immediate field = INSTR[7:4]; INSTR[3:0] is ignored.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level; 1 = free-run, 0 = stop after the current instruction.
- STEP  in  1  one-cycle pulse; executes exactly one instruction when in IDLE.
- ROM_ADDR  out  ADDR_WIDTH  equals PC; the ROM is combinational.
- ROM_DATA  in  INSTR_WIDTH  instruction word returned by the ROM.
- DP_READY  in  1  datapath can accept a commit this cycle.
- ACC_SEL  out  3  A source select: 0 hold, 1 IMM, 2 A+1, 3 A+R, 4 R.
- ACC_WE  out  1  A write strobe.
- REG_WE  out  1  R write strobe (R<=A).
- IMM  out  IMM_WIDTH  immediate field of the latched instruction.
- HALTED  out  1  high while in HALT.
- ILLEGAL  out  1  one-cycle pulse when an undefined opcode is executed.

Behaviour:
- Reset (RST_N=0, asynchronous): PC=0, IR=12'hC00, state IDLE. All outputs 0, except ROM_ADDR=0.
- State machine:
  - IDLE: go to FETCH if RUN=1 or STEP=1. The STEP source is captured in a step_mode flag.
  - FETCH (1 cycle): IR<=ROM_DATA; PC<=PC+1, wrapping 15->0; go to DECODE.
  - DECODE (1 cycle): register ACC_SEL and IMM from IR; go to EXEC.
  - EXEC: ACC_SEL and IMM are held stable. Strobes are combinational: WE = EXEC & DP_READY & op-writes, so each strobe lasts exactly one cycle. The datapath commits on that edge.
  - EXEC while DP_READY=0: stay in EXEC (stall), strobes stay low.
  - EXEC exit (when DP_READY=1): go to HALT if the op is HALT; otherwise go to FETCH if RUN=1 and step_mode=0, else IDLE.
  - HALT: HALTED=1, no strobes; leave only via RST_N.
- Minimum latency: 3 cycles per instruction (FETCH, DECODE, EXEC with DP_READY=1).
- Opcodes:
  - 0x5 ADD: ACC_SEL=3, ACC_WE.
  - 0x9 INC: ACC_SEL=2, ACC_WE.
  - 0xA LD: ACC_SEL=4, ACC_WE.
  - 0xB ST: REG_WE.
  - 0xC NOP: no strobe.
  - 0xD LDI: ACC_SEL=1, ACC_WE; IMM = INSTR[7:4], zero-extended by the datapath.
  - 0xE RST: PC<=0 on the EXEC exit edge; no strobe.
  - 0xF HALT.
  - Any other opcode: treated as NOP, with an ILLEGAL pulse on the EXEC exit edge.
- RUN falls mid-instruction: the instruction completes normally, then the block goes to IDLE.
- STEP while not in IDLE: ignored.
- RUN=1 and STEP=1 together in IDLE: free-run (step_mode=0).
- PC wrap: sequential fetch from address 15 continues at 0.
- RST opcode at address 15: PC=0 (RST has priority over the wrap increment).
- Reset asserted in any state, including a stalled EXEC: immediate return to reset values; no strobe is emitted.

Decomposition:
- Shared package: opcode constants (OP_ADD=4'h5, OP_INC=4'h9, OP_LD=4'hA, OP_ST=4'hB, OP_NOP=4'hC, OP_LDI=4'hD, OP_RST=4'hE, OP_HALT=4'hF), state encoding (IDLE, FETCH, DECODE, EXEC, HALT) and ACC_SEL encodings.
- Sub-module instr_decode: purely combinational, maps opcode to {acc_sel, acc_we_en, reg_we_en, is_rst, is_halt, illegal}.

Test Plan:
- Reset, then RUN=1, DP_READY=1, program D20/900/B00: ROM_ADDR 0,1,2 at 3-cycle spacing; ACC_WE with ACC_SEL=1 and IMM=2; then ACC_WE with ACC_SEL=2; then a single REG_WE pulse.
- DP_READY held 0 for 4 cycles during EXEC of 0x500: ACC_SEL=3 stays stable and ACC_WE=0; when DP_READY=1, exactly one ACC_WE cycle; next FETCH follows on the following cycle.
- RUN=0, one STEP pulse in IDLE: exactly one instruction executes; ROM_ADDR advances by 1; state returns to IDLE and holds there for 10 cycles.
- 0xE00 at address 14, and separately at address 15: next ROM_ADDR=0 in both cases; a program of 16 NOPs wraps 15->0.
- 0x300 executed: no strobes, one ILLEGAL pulse, PC advances. 0xF00 executed: HALTED=1, RUN toggling has no effect, RST_N low clears HALTED to 0 and PC to 0.
- RST_N asserted asynchronously (mid-cycle) during a stalled EXEC: outputs go to 0 and ROM_ADDR to 0 immediately, with no clock edge needed; no ACC_WE is emitted.
